icache_fill: RTL and testbench

Direct-mapped instruction cache that answers the fetch stage's read_req/read_ack handshake and refills lines from backing instruction memory over a second req/ack handshake. Sits between fetch and the instruction memory bus. On a hit it acks in the same cycle. On a miss it stalls fetch (ack low) until the line is loaded.

---
 rtl/icache_pkg.sv | 26 ++
 rtl/icache_refill_fsm.sv | 97 +++++++++
 rtl/icache_fill.sv | 130 +++++++++++++
 tb/tb_icache_fill.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: shared FSM encoding and address-split width helpers for the instruction cache.
// Contents:
//   state_e         - refill FSM state encoding (ST_IDLE, ST_REFILL)
//   calc_offset_w() - word-offset width within a line
//   calc_index_w()  - line-index width
//   calc_tag_w()    - tag width left over from the word address
package icache_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_REFILL = 1'b1
    } state_e;

    function automatic int calc_offset_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int calc_index_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int calc_tag_w(input int pc_width, input int lines, input int line_words);
        return pc_width - $clog2(lines) - $clog2(line_words);
    endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// icache_refill_fsm: refill sequencer that fetches one cache line word-by-word from backing memory.
// Ports:
//   i_clk, i_arst_n - clock, asynchronous active-low reset
//   i_miss          - lookup missed (only acted on in IDLE)
//   i_flush         - invalidate pulse; marks an in-flight refill as not-to-be-validated
//   i_line          - line address (word address with offset stripped) of the missing fetch
//   i_mem_ack       - backing word returned this cycle
//   o_idle          - FSM in IDLE (lookups allowed)
//   o_start         - IDLE->REFILL transition this cycle
//   o_mem_req       - backing-memory request
//   o_mem_addr      - backing-memory word address
//   o_wr_en/o_wr_off- write the returned word into the latched line at this offset
//   o_fill_line     - latched line address (index and tag source)
//   o_fill_done     - last word of the line accepted this cycle
//   o_fill_valid    - the finished line may be marked valid
module icache_refill_fsm
    import icache_pkg::*;
#(
    parameter int LINE_W = 28,
    parameter int OFF_W  = 2
) (
    input  logic                    i_clk,
    input  logic                    i_arst_n,
    input  logic                    i_miss,
    input  logic                    i_flush,
    input  logic [LINE_W-1:0]       i_line,
    input  logic                    i_mem_ack,
    output logic                    o_idle,
    output logic                    o_start,
    output logic                    o_mem_req,
    output logic [LINE_W+OFF_W-1:0] o_mem_addr,
    output logic                    o_wr_en,
    output logic [OFF_W-1:0]        o_wr_off,
    output logic [LINE_W-1:0]       o_fill_line,
    output logic                    o_fill_done,
    output logic                    o_fill_valid
);

    state_e              state_q, state_d;
    logic [OFF_W-1:0]    cnt_q, cnt_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic                pend_q, pend_d;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        line_d      = line_q;
        pend_d      = pend_q;
        o_start     = 1'b0;
        o_mem_req   = 1'b0;
        o_wr_en     = 1'b0;
        o_fill_done = 1'b0;
        if (state_q == ST_IDLE) begin
            if (i_miss) begin
                state_d = ST_REFILL;
                line_d  = i_line;
                cnt_d   = '0;
                o_start = 1'b1;
            end
        end else begin
            o_mem_req = 1'b1;
            if (i_flush)
                pend_d = 1'b1;
            if (i_mem_ack) begin
                o_wr_en = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (&cnt_q) begin
                    o_fill_done = 1'b1;
                    state_d     = ST_IDLE;
                    pend_d      = 1'b0;
                end
            end
        end
    end

    assign o_idle       = (state_q == ST_IDLE);
    assign o_mem_addr   = o_mem_req ? {line_q, cnt_q} : '0;
    assign o_wr_off     = cnt_q;
    assign o_fill_line  = line_q;
    // A flush on the final-ack edge must also leave the line invalid.
    assign o_fill_valid = ~pend_q & ~i_flush;

endmodule

// File: rtl/icache_fill.sv
// icache_fill: direct-mapped instruction cache with 0-cycle hits and in-order line refill.
// Ports:
//   i_clk, i_arst_n          - clock, asynchronous active-low reset
//   i_read_req, i_pc         - fetch request and word address
//   o_read_ack, o_instr      - combinational hit and instruction (0 when no ack)
//   i_flush                  - invalidate all lines
//   o_mem_req, o_mem_addr    - backing-memory word request
//   i_mem_ack, i_mem_data    - backing-memory response
//   o_hit_cnt, o_miss_cnt    - statistics, present only when ICACHE_STATS_EN is defined
module icache_fill
    import icache_pkg::*;
#(
    parameter  int INSTR_ADDR_WIDTH = 32,
    parameter  int INSTR_WIDTH      = 32,
    parameter  int LINE_WORDS       = 4,
    parameter  int LINES            = 16,
    localparam int PC_WIDTH         = INSTR_ADDR_WIDTH - 2
) (
    input  logic                   i_clk,
    input  logic                   i_arst_n,
    input  logic                   i_read_req,
    input  logic [PC_WIDTH-1:0]    i_pc,
    output logic                   o_read_ack,
    output logic [INSTR_WIDTH-1:0] o_instr,
    input  logic                   i_flush,
    output logic                   o_mem_req,
    output logic [PC_WIDTH-1:0]    o_mem_addr,
    input  logic                   i_mem_ack,
    input  logic [INSTR_WIDTH-1:0] i_mem_data
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]            o_hit_cnt,
    output logic [31:0]            o_miss_cnt
`endif
);

    localparam int OFFSET_W = calc_offset_w(LINE_WORDS);
    localparam int INDEX_W  = calc_index_w(LINES);
    localparam int TAG_W    = calc_tag_w(PC_WIDTH, LINES, LINE_WORDS);
    localparam int LINE_W   = PC_WIDTH - OFFSET_W;

    logic [LINES-1:0]       valid_q, valid_d;
    logic [TAG_W-1:0]       tag_q  [LINES];
    logic [INSTR_WIDTH-1:0] data_q [LINES][LINE_WORDS];

    logic [OFFSET_W-1:0] pc_off;
    logic [INDEX_W-1:0]  pc_idx;
    logic [TAG_W-1:0]    pc_tag;
    logic                lookup_hit, hit, miss, idle, start;
    logic                wr_en, fill_done, fill_valid;
    logic [OFFSET_W-1:0] wr_off;
    logic [LINE_W-1:0]   fill_line;
    logic [INDEX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]    fill_tag;

    assign pc_off     = i_pc[OFFSET_W-1:0];
    assign pc_idx     = i_pc[OFFSET_W +: INDEX_W];
    assign pc_tag     = i_pc[PC_WIDTH-1 -: TAG_W];
    assign lookup_hit = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign hit        = i_read_req & idle & ~i_flush & lookup_hit;
    assign miss       = i_read_req & ~i_flush & ~lookup_hit;
    assign o_read_ack = hit;
    assign o_instr    = hit ? data_q[pc_idx][pc_off] : '0;
    assign fill_idx   = fill_line[INDEX_W-1:0];
    assign fill_tag   = fill_line[LINE_W-1 -: TAG_W];

    icache_refill_fsm #(
        .LINE_W (LINE_W),
        .OFF_W  (OFFSET_W)
    ) u_fsm (
        .i_clk        (i_clk),
        .i_arst_n     (i_arst_n),
        .i_miss       (miss),
        .i_flush      (i_flush),
        .i_line       (i_pc[PC_WIDTH-1:OFFSET_W]),
        .i_mem_ack    (i_mem_ack),
        .o_idle       (idle),
        .o_start      (start),
        .o_mem_req    (o_mem_req),
        .o_mem_addr   (o_mem_addr),
        .o_wr_en      (wr_en),
        .o_wr_off     (wr_off),
        .o_fill_line  (fill_line),
        .o_fill_done  (fill_done),
        .o_fill_valid (fill_valid)
    );

    always_comb begin
        valid_d = valid_q;
        if (fill_done && fill_valid)
            valid_d[fill_idx] = 1'b1;
        if (i_flush)
            valid_d = '0;
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n)
            valid_q <= '0;
        else
            valid_q <= valid_d;
    end

    // Data and tags carry no reset; valid bits alone gate their use.
    always_ff @(posedge i_clk) begin
        if (wr_en)
            data_q[fill_idx][wr_off] <= i_mem_data;
        if (fill_done)
            tag_q[fill_idx] <= fill_tag;
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit)
                hit_cnt_q <= hit_cnt_q + 32'd1;
            if (start)
                miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign o_hit_cnt  = hit_cnt_q;
    assign o_miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_fill.sv
// tb_icache_fill: scoreboard bench for icache_fill (instruction and memory-address queues checked by a monitor).
module tb_icache_fill;

    logic        clk = 1'b0;
    logic        i_arst_n = 1'b0;
    logic        i_read_req = 1'b0;
    logic [29:0] i_pc = '0;
    logic        o_read_ack;
    logic [31:0] o_instr;
    logic        i_flush = 1'b0;
    logic        o_mem_req;
    logic [29:0] o_mem_addr;
    logic        i_mem_ack;
    logic [31:0] i_mem_data;
`ifdef ICACHE_STATS_EN
    logic [31:0] o_hit_cnt, o_miss_cnt;
`endif

    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] exp_q[$];
    logic [29:0] addr_q[$];
    bit          slow = 1'b0;
    int          wc = 0;
    bit          prev_pend = 1'b0;
    logic [29:0] prev_addr = '0;

    always #5 clk = ~clk;

    icache_fill dut (
        .i_clk      (clk),
        .i_arst_n   (i_arst_n),
        .i_read_req (i_read_req),
        .i_pc       (i_pc),
        .o_read_ack (o_read_ack),
        .o_instr    (o_instr),
        .i_flush    (i_flush),
        .o_mem_req  (o_mem_req),
        .o_mem_addr (o_mem_addr),
        .i_mem_ack  (i_mem_ack),
        .i_mem_data (i_mem_data)
`ifdef ICACHE_STATS_EN
        ,
        .o_hit_cnt  (o_hit_cnt),
        .o_miss_cnt (o_miss_cnt)
`endif
    );

    // Memory model: word data is 0xA000_0000 + address; slow mode acks every third request cycle.
    assign i_mem_ack  = o_mem_req && (!slow || wc == 2);
    assign i_mem_data = 32'hA000_0000 + {2'b00, o_mem_addr};

    always @(posedge clk) wc <= (o_mem_req && !i_mem_ack) ? wc + 1 : 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        else
            n_pass++;
    endtask

    always @(negedge clk) begin
        if (i_arst_n) begin
            if (o_read_ack) begin
                if (exp_q.size() == 0)
                    chk("unexpected_ack", 32'd1, 32'd0);
                else
                    chk("instr", o_instr, exp_q.pop_front());
            end
            if (o_mem_req && i_mem_ack) begin
                if (addr_q.size() == 0)
                    chk("unexpected_mem_ack", 32'd1, 32'd0);
                else
                    chk("mem_addr", {2'b00, o_mem_addr}, {2'b00, addr_q.pop_front()});
            end
            if (o_mem_req && prev_pend)
                chk("addr_hold", {2'b00, o_mem_addr}, {2'b00, prev_addr});
            prev_pend = o_mem_req && !i_mem_ack;
            prev_addr = o_mem_addr;
        end else begin
            prev_pend = 1'b0;
        end
    end

    task automatic push_fill(input logic [29:0] pc);
        for (int k = 0; k < 4; k++)
            addr_q.push_back({pc[29:2], 2'(k)});
    endtask

    task automatic wait_ack(input int lat, input string nm);
        int n = 0;
        @(negedge clk);
        while (!o_read_ack && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(nm, n, lat);
        @(posedge clk); #1;
        i_read_req = 1'b0;
    endtask

    task automatic fetch(input logic [29:0] pc, input int lat, input string nm);
        i_pc = pc;
        i_read_req = 1'b1;
        exp_q.push_back(32'hA000_0000 + {2'b00, pc});
        if (lat > 0)
            push_fill(pc);
        wait_ack(lat, nm);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        #3;
        chk("rst_ack", {31'd0, o_read_ack}, 32'd0);
        chk("rst_instr", o_instr, 32'd0);
        chk("rst_mem_req", {31'd0, o_mem_req}, 32'd0);
        chk("rst_mem_addr", {2'b00, o_mem_addr}, 32'd0);
        repeat (2) @(posedge clk);
        #1 i_arst_n = 1'b1;

        fetch(30'h10, 5, "cold_miss_lat");
        fetch(30'h11, 0, "hit_11");
        fetch(30'h12, 0, "hit_12");
        fetch(30'h13, 0, "hit_13");

        slow = 1'b1;
        fetch(30'h24, 13, "wait_state_lat");
        slow = 1'b0;

        fetch(30'h00, 5, "conflict_fill0");
        fetch(30'h40, 5, "conflict_fill40");
        fetch(30'h00, 5, "conflict_refetch0");

        i_pc = 30'h20;
        i_read_req = 1'b1;
        push_fill(30'h20);
        tick();
        tick();
        i_pc = 30'h80;
        push_fill(30'h80);
        exp_q.push_back(32'hA000_0080);
        wait_ack(8, "jump_lat");
        fetch(30'h20, 0, "jump_rehit");

        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        fetch(30'h20, 5, "flush_idle_miss");

        i_pc = 30'h30;
        i_read_req = 1'b1;
        push_fill(30'h30);
        push_fill(30'h30);
        exp_q.push_back(32'hA000_0030);
        tick();
        tick();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        wait_ack(7, "flush_refill_lat");

        i_pc = 30'h30;
        i_read_req = 1'b1;
        i_flush = 1'b1;
        @(negedge clk);
        chk("flush_suppress_ack", {31'd0, o_read_ack}, 32'd0);
        tick();
        i_flush = 1'b0;
        push_fill(30'h30);
        exp_q.push_back(32'hA000_0030);
        wait_ack(5, "flush_hit_miss");

`ifdef ICACHE_STATS_EN
        chk("miss_cnt", o_miss_cnt, 32'd11);
        chk("hit_cnt", o_hit_cnt, 32'd13);
`endif

        i_pc = 30'h04;
        i_read_req = 1'b1;
        addr_q.push_back(30'h04);
        tick();
        tick();
        i_arst_n = 1'b0;
        #1;
        chk("rst_mid_mem_req", {31'd0, o_mem_req}, 32'd0);
        chk("rst_mid_mem_addr", {2'b00, o_mem_addr}, 32'd0);
        chk("rst_mid_ack", {31'd0, o_read_ack}, 32'd0);
        i_read_req = 1'b0;
        tick();
        i_arst_n = 1'b1;
        fetch(30'h30, 5, "post_reset_miss");
`ifdef ICACHE_STATS_EN
        chk("post_reset_miss_cnt", o_miss_cnt, 32'd1);
`endif

        repeat (2) tick();
        chk("instr_queue_empty", exp_q.size(), 32'd0);
        chk("addr_queue_empty", addr_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
